// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state type, used by both the
// transmitter and the receiver on the 115200-baud link.
package uart_pkg;

    // 50 MHz / 115200 baud, rounded to an even divisor so the half-bit is exact.
    localparam int CLKS_PER_BIT_115200 = 434;
    localparam int HALF_BIT_115200     = 217;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Brings the asynchronous rx line into the 50 MHz domain and flags the
// falling edge that marks a possible start bit.
module uart_rx_sync (
    input  logic clock_50mhz,
    input  logic reset,
    input  logic rx_pin,
    output logic rx_s,
    output logic start_edge
);

    logic rx_m;
    logic rx_p;

    // Two-flop synchronizer plus a history flop. Everything resets to 0 so a
    // line that is already low when reset releases never looks like a 1->0 edge.
    always_ff @(posedge clock_50mhz) begin
        if (reset) begin
            rx_m <= 1'b0;
            rx_s <= 1'b0;
            rx_p <= 1'b0;
        end else begin
            rx_m <= rx_pin;
            rx_s <= rx_m;
            rx_p <= rx_s;
        end
    end

    assign start_edge = rx_p & ~rx_s;

endmodule

// File: rtl/uart_read.sv
// 8N1 UART receiver, LSB first, sampled at mid-bit.
//
// Output handshake: `valid` pulses for exactly one cycle when `data` takes a
// new good byte, and `ready` rises in that same cycle. `ready` is a level that
// stays high until the consumer raises `ack`; `ack` is a level, sampled every
// cycle, and while high it clears `ready` and `overrun` on the next cycle
// (no effect if already clear). A good byte landing while `ready` is still
// high and `ack` is low sets the sticky `overrun`; if `ack` is high in that
// very cycle it consumes the old byte, so `ready` stays 1 and no overrun.
module uart_read
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200
) (
    input  logic       clock_50mhz,
    input  logic       reset,
    input  logic       rx_pin,
    input  logic       ack,
    output logic [7:0] data,
    output logic       valid,
    output logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output rx_state_t  state
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_s;
    logic             start_edge;

    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    rx_state_t        state_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       bit_idx_nxt;
    logic [7:0]       shreg_nxt;
    logic [7:0]       data_nxt;
    logic             valid_nxt;
    logic             ready_nxt;
    logic             frame_err_nxt;
    logic             overrun_nxt;

    uart_rx_sync u_sync (
        .clock_50mhz (clock_50mhz),
        .reset       (reset),
        .rx_pin      (rx_pin),
        .rx_s        (rx_s),
        .start_edge  (start_edge)
    );

    // State and output registers; reset mid-frame drops the partial byte.
    always_ff @(posedge clock_50mhz) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            ready     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shreg     <= shreg_nxt;
            data      <= data_nxt;
            valid     <= valid_nxt;
            ready     <= ready_nxt;
            frame_err <= frame_err_nxt;
            overrun   <= overrun_nxt;
        end
    end

    // Next-state and output logic; frame completion at mid stop bit returns
    // straight to IDLE so the next start edge can follow with no gap.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        bit_idx_nxt   = bit_idx;
        shreg_nxt     = shreg;
        data_nxt      = data;
        valid_nxt     = 1'b0;
        frame_err_nxt = 1'b0;
        ready_nxt     = ack ? 1'b0 : ready;
        overrun_nxt   = ack ? 1'b0 : overrun;

        case (state)
            IDLE: begin
                cnt_nxt     = '0;
                bit_idx_nxt = '0;
                if (start_edge) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = rx_s ? IDLE : DATA;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt            = '0;
                    shreg_nxt[bit_idx] = rx_s;
                    if (bit_idx == 3'd7) begin
                        bit_idx_nxt = '0;
                        state_nxt   = STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                    if (rx_s) begin
                        data_nxt  = shreg;
                        valid_nxt = 1'b1;
                        ready_nxt = 1'b1;
                        if (ready && !ack) begin
                            overrun_nxt = 1'b1;
                        end
                    end else begin
                        frame_err_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
